// File: rtl/vga_pkg.sv
// Shared VGA timing constants, sync polarity type and derived totals.
// Defaults describe 640x480@60 Hz driven by a 25 MHz pixel tick.
package vga_pkg;

  typedef enum logic {
    SYNC_ACTIVE_LOW  = 1'b0,
    SYNC_ACTIVE_HIGH = 1'b1
  } sync_pol_e;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Modulo-N counter with enable; wrap_o flags the enabled step from N-1 back to 0.
module vga_axis_counter #(
  parameter int N = 800,
  parameter int W = 10
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         at_last;

  assign at_last = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = at_last ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign wrap_o = en_i && at_last;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA horizontal/vertical timing generator: counts pixel ticks and registers
// sync, blanking, coordinates and line/frame strobes one tick behind the counters.
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int        H_ACTIVE = VGA_H_ACTIVE,
  parameter int        H_FP     = VGA_H_FP,
  parameter int        H_SYNC   = VGA_H_SYNC,
  parameter int        H_BP     = VGA_H_BP,
  parameter int        V_ACTIVE = VGA_V_ACTIVE,
  parameter int        V_FP     = VGA_V_FP,
  parameter int        V_SYNC   = VGA_V_SYNC,
  parameter int        V_BP     = VGA_V_BP,
  parameter sync_pol_e SYNC_POL = SYNC_ACTIVE_LOW,
  localparam int       H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int       V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int       CW       = $clog2(max_int(H_TOTAL, V_TOTAL))
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pix_tick,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic          line_end,
  output logic          frame_end
);

  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
      H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_param_check
    $error("vga_sync_gen: invalid timing parameters");
  end

  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic          SYNC_ON  = (SYNC_POL == SYNC_ACTIVE_HIGH);
  localparam logic          SYNC_OFF = ~SYNC_ON;

  logic [CW-1:0] h_cnt, v_cnt;
  logic          h_wrap, v_wrap;

  vga_axis_counter #(.N(H_TOTAL), .W(CW)) u_h_cnt (
    .clk_i  (clk),
    .rst_ni (reset),
    .en_i   (pix_tick),
    .cnt_o  (h_cnt),
    .wrap_o (h_wrap)
  );

  // The vertical counter's wrap already implies the horizontal wrap, i.e. frame end.
  vga_axis_counter #(.N(V_TOTAL), .W(CW)) u_v_cnt (
    .clk_i  (clk),
    .rst_ni (reset),
    .en_i   (h_wrap),
    .cnt_o  (v_cnt),
    .wrap_o (v_wrap)
  );

  logic hsync_d, vsync_d, video_on_d;

  always_comb begin
    hsync_d    = ((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST)) ? SYNC_ON : SYNC_OFF;
    vsync_d    = ((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST)) ? SYNC_ON : SYNC_OFF;
    video_on_d = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  end

  logic          hsync_q, vsync_q, video_on_q, line_end_q, frame_end_q;
  logic [CW-1:0] pixel_x_q, pixel_y_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hsync_q     <= SYNC_OFF;
      vsync_q     <= SYNC_OFF;
      video_on_q  <= 1'b0;
      pixel_x_q   <= '0;
      pixel_y_q   <= '0;
      line_end_q  <= 1'b0;
      frame_end_q <= 1'b0;
    end else begin
      line_end_q  <= h_wrap;
      frame_end_q <= v_wrap;
      if (pix_tick) begin
        hsync_q    <= hsync_d;
        vsync_q    <= vsync_d;
        video_on_q <= video_on_d;
        pixel_x_q  <= h_cnt;
        pixel_y_q  <= v_cnt;
      end
    end
  end

  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign video_on  = video_on_q;
  assign pixel_x   = pixel_x_q;
  assign pixel_y   = pixel_y_q;
  assign line_end  = line_end_q;
  assign frame_end = frame_end_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: default 640x480 instance for line timing, hold and async reset;
// a small 16x10 active-high instance for full-frame sequencing with sparse ticks.
module tb_vga_sync_gen;
  import vga_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic pix_tick = 1'b0;

  logic       d_hs, d_vs, d_von, d_le, d_fe;
  logic [9:0] d_px, d_py;
  logic       s_hs, s_vs, s_von, s_le, s_fe;
  logic [3:0] s_px, s_py;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  vga_sync_gen u_dut (
    .clk(clk), .reset(reset), .pix_tick(pix_tick),
    .hsync(d_hs), .vsync(d_vs), .video_on(d_von),
    .pixel_x(d_px), .pixel_y(d_py), .line_end(d_le), .frame_end(d_fe)
  );

  // 16 x 10 total; hsync for h 10..12, vsync for v 7..8, active 8 x 6.
  vga_sync_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(SYNC_ACTIVE_HIGH)
  ) u_small (
    .clk(clk), .reset(reset), .pix_tick(pix_tick),
    .hsync(s_hs), .vsync(s_vs), .video_on(s_von),
    .pixel_x(s_px), .pixel_y(s_py), .line_end(s_le), .frame_end(s_fe)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d want=%0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_dflt_reset(input string tag);
    chk({tag, "_px"}, d_px, 0);
    chk({tag, "_py"}, d_py, 0);
    chk({tag, "_von"}, d_von, 0);
    chk({tag, "_hs"}, d_hs, 1);
    chk({tag, "_vs"}, d_vs, 1);
    chk({tag, "_le"}, d_le, 0);
    chk({tag, "_fe"}, d_fe, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hs_low, le_cnt, changes, fe_cnt, n, ex, ey;
    logic tk;
    logic [9:0] hold_px, hold_py;
    logic hold_hs, hold_vs, hold_von;

    // Reset held while pix_tick toggles.
    for (int i = 0; i < 6; i++) begin
      pix_tick = i[0];
      step();
    end
    chk_dflt_reset("rst");
    chk("rst_s_hs", s_hs, 0);
    chk("rst_s_vs", s_vs, 0);
    chk("rst_s_von", s_von, 0);

    // Release, then first tick shows (0,0) in the active area.
    pix_tick = 1'b0;
    reset = 1'b1;
    step();
    chk_dflt_reset("idle");
    pix_tick = 1'b1;
    step();
    chk("t0_px", d_px, 0);
    chk("t0_py", d_py, 0);
    chk("t0_von", d_von, 1);
    chk("t0_hs", d_hs, 1);
    chk("t0_vs", d_vs, 1);

    // One full line with a tick every clock.
    hs_low = 0;
    le_cnt = 0;
    for (int k = 1; k <= 800; k++) begin
      step();
      if (!d_hs) hs_low++;
      if (d_le) le_cnt++;
      case (k)
        639: chk("von_639", d_von, 1);
        640: chk("von_640", d_von, 0);
        655: chk("hs_655", d_hs, 1);
        656: chk("hs_656", d_hs, 0);
        751: chk("hs_751", d_hs, 0);
        752: chk("hs_752", d_hs, 1);
        799: begin
          chk("le_px", d_px, 799);
          chk("le_799", d_le, 1);
          chk("fe_799", d_fe, 0);
          chk("vs_line0", d_vs, 1);
        end
        800: begin
          chk("wrap_px", d_px, 0);
          chk("wrap_py", d_py, 1);
          chk("wrap_le", d_le, 0);
          chk("wrap_fe", d_fe, 0);
          chk("wrap_von", d_von, 1);
        end
        default: ;
      endcase
    end
    chk("hs_low_ticks", hs_low, 96);
    chk("le_count", le_cnt, 1);

    // Advance mid-line, then hold pix_tick low for 1000 clocks.
    for (int k = 0; k < 99; k++) step();
    chk("pre_hold_px", d_px, 99);
    chk("pre_hold_py", d_py, 1);
    pix_tick = 1'b0;
    hold_px = d_px;
    hold_py = d_py;
    hold_hs = d_hs;
    hold_vs = d_vs;
    hold_von = d_von;
    changes = 0;
    for (int k = 0; k < 1000; k++) begin
      step();
      if (d_px !== hold_px || d_py !== hold_py || d_hs !== hold_hs ||
          d_vs !== hold_vs || d_von !== hold_von || d_le !== 1'b0 || d_fe !== 1'b0)
        changes++;
    end
    chk("hold_changes", changes, 0);
    pix_tick = 1'b1;
    step();
    chk("resume_px", d_px, 100);
    chk("resume_py", d_py, 1);

    // Move to h=300 then pulse reset between clock edges.
    for (int k = 0; k < 200; k++) step();
    chk("mid_px", d_px, 300);
    pix_tick = 1'b0;
    #3;
    reset = 1'b0;
    #1;
    chk_dflt_reset("async");
    #2;
    reset = 1'b1;
    pix_tick = 1'b1;
    step();
    chk("rel_px", d_px, 0);
    chk("rel_py", d_py, 0);
    chk("rel_von", d_von, 1);
    chk("rel_hs", d_hs, 1);
    step();
    chk("rel2_px", d_px, 1);
    chk("rel2_py", d_py, 0);

    // Small instance: two frames with a tick every 4th clock.
    pix_tick = 1'b0;
    reset = 1'b0;
    #2;
    reset = 1'b1;
    n = -1;
    fe_cnt = 0;
    for (int c = 0; c < 1300; c++) begin
      tk = (c % 4 == 0);
      pix_tick = tk;
      step();
      if (tk) n++;
      ex = n % 16;
      ey = (n / 16) % 10;
      chk("s_px", s_px, ex);
      chk("s_py", s_py, ey);
      chk("s_hs", s_hs, (ex >= 10 && ex <= 12));
      chk("s_vs", s_vs, (ey >= 7 && ey <= 8));
      chk("s_von", s_von, (ex < 8 && ey < 6));
      chk("s_le", s_le, (tk && ex == 15));
      chk("s_fe", s_fe, (tk && ex == 15 && ey == 9));
      if (s_fe) fe_cnt++;
    end
    chk("s_fe_count", fe_cnt, 2);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
